// File: rtl/double_buffer_pkg.sv
// Shared types and defaults for the HDMI-to-matrix double-buffer control path.
// Holds the swap sequencer state encoding and the default timing parameters.
package double_buffer_pkg;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    FILLING = 3'd1,
    PENDING = 3'd2,
    SWAP    = 3'd3,
    SETTLE  = 3'd4
  } swap_state_t;

  localparam int unsigned DEF_SWAP_PULSE_CYCLES = 4;
  localparam int unsigned DEF_SETTLE_CYCLES     = 8;
  localparam int unsigned DEF_CNT_WIDTH         = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Status event counter with synchronous reset/clear; either wraps or
// saturates at all-ones depending on SATURATE.
module sat_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: combinational blocks use blocking '=' and start from a default so no
  // latch is inferred; only the always_ff block below uses non-blocking '<='.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (!SATURATE || (count_q != '1)) begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/buffer_swap_controller.sv
// Frame-level sequencer for the double buffer: decides when write and read
// halves swap, gates the writer, restarts scan-out and counts frames.
module buffer_swap_controller
  import double_buffer_pkg::*;
#(
  parameter int unsigned SWAP_PULSE_CYCLES = DEF_SWAP_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_frame_start,
  input  logic                 write_frame_done,
  input  logic                 read_frame_done,
  output logic                 write_allow,
  output logic                 read_start,
  output logic                 swap_trigger,
  output logic                 data_valid,
  output logic [CNT_WIDTH-1:0] frames_swapped,
  output logic [CNT_WIDTH-1:0] frames_dropped
);

  localparam int unsigned CYC_W = $clog2(max_u(SWAP_PULSE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CYC_W-1:0] SWAP_LOAD   = CYC_W'(SWAP_PULSE_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_LOAD = CYC_W'(SETTLE_CYCLES - 1);

  if (SWAP_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("SWAP_PULSE_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  swap_state_t      state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             read_busy_q, read_busy_d;
  logic             write_allow_q, write_allow_d;
  logic             read_start_q, read_start_d;
  logic             swap_trigger_q, swap_trigger_d;
  logic             data_valid_q, data_valid_d;

  logic             rfd_valid;
  logic             wfd_valid;
  logic             swap_entry;
  logic             drop_inc;

  always_comb begin
    // Events that arrive while their side is not active are discarded here.
    rfd_valid    = read_frame_done && read_busy_q;
    wfd_valid    = write_frame_done && write_allow_q;
    state_d      = state_q;
    cyc_d        = cyc_q;
    read_start_d = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (wfd_valid) state_d = SWAP;
      end
      FILLING: begin
        if (wfd_valid) begin
          if (!read_busy_q || rfd_valid) state_d = SWAP;
          else                           state_d = PENDING;
        end else if (rfd_valid) begin
          read_start_d = 1'b1;
        end
      end
      PENDING: begin
        if (rfd_valid) state_d = SWAP;
      end
      SWAP: begin
        if (cyc_q == '0) begin
          state_d = SETTLE;
          cyc_d   = SETTLE_LOAD;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      SETTLE: begin
        if (cyc_q == '0) begin
          state_d      = FILLING;
          read_start_d = 1'b1;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      default: state_d = EMPTY;
    endcase

    swap_entry = (state_d == SWAP) && (state_q != SWAP);
    if (swap_entry) cyc_d = SWAP_LOAD;

    read_busy_d    = (read_busy_q && !rfd_valid) || read_start_d;
    write_allow_d  = (state_d == EMPTY) || (state_d == FILLING);
    swap_trigger_d = (state_d == SWAP);
    data_valid_d   = data_valid_q || swap_entry;
    drop_inc       = write_frame_start && !write_allow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      cyc_q          <= '0;
      read_busy_q    <= 1'b0;
      write_allow_q  <= 1'b1;
      read_start_q   <= 1'b0;
      swap_trigger_q <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      read_busy_q    <= read_busy_d;
      write_allow_q  <= write_allow_d;
      read_start_q   <= read_start_d;
      swap_trigger_q <= swap_trigger_d;
      data_valid_q   <= data_valid_d;
    end
  end

  sat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b0)
  ) u_swapped_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (swap_entry),
    .count (frames_swapped)
  );

  sat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b1)
  ) u_dropped_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (drop_inc),
    .count (frames_dropped)
  );

  assign write_allow  = write_allow_q;
  assign read_start   = read_start_q;
  assign swap_trigger = swap_trigger_q;
  assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_buffer_swap_controller.sv
// Self-checking bench for buffer_swap_controller: directed scenarios followed by
// random event pulses, compared each cycle against a timestamp-based model.
module tb_buffer_swap_controller;

  localparam int P = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wfs = 1'b0;
  logic wfd = 1'b0;
  logic rfd = 1'b0;

  logic        wa, rs, st, dv;
  logic [15:0] fs, fd;
  logic        wa2, rs2, st2, dv2;
  logic [1:0]  fs2, fd2;

  always #5 clk = ~clk;

  buffer_swap_controller #(
    .SWAP_PULSE_CYCLES (P),
    .SETTLE_CYCLES     (S),
    .CNT_WIDTH         (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .write_frame_start (wfs),
    .write_frame_done  (wfd),
    .read_frame_done   (rfd),
    .write_allow       (wa),
    .read_start        (rs),
    .swap_trigger      (st),
    .data_valid        (dv),
    .frames_swapped    (fs),
    .frames_dropped    (fd)
  );

  buffer_swap_controller #(
    .SWAP_PULSE_CYCLES (P),
    .SETTLE_CYCLES     (S),
    .CNT_WIDTH         (2)
  ) dut_narrow (
    .clk               (clk),
    .rst               (rst),
    .write_frame_start (wfs),
    .write_frame_done  (wfd),
    .read_frame_done   (rfd),
    .write_allow       (wa2),
    .read_start        (rs2),
    .swap_trigger      (st2),
    .data_valid        (dv2),
    .frames_swapped    (fs2),
    .frames_dropped    (fd2)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Model: everything is derived from the input cycle of the last swap event.
  int last_swap = -1000;
  bit m_pending, m_busy, m_valid, m_wa, m_rs, m_st;
  int m_swapped, m_dropped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_edge(input bit r, input bit w_start, input bit w_done, input bit r_done);
    int  prev_age, age;
    bit  rfd_v, busy_before, new_swap, rescan;
    if (r) begin
      m_pending = 0; m_busy = 0; m_valid = 0;
      m_wa = 1; m_rs = 0; m_st = 0;
      m_swapped = 0; m_dropped = 0;
      last_swap = -1000;
      return;
    end
    prev_age    = edge_n - 1 - last_swap;
    busy_before = m_busy;
    rfd_v       = r_done && busy_before;
    new_swap    = 0;
    rescan      = 0;
    if (w_start && !m_wa) m_dropped++;
    if (rfd_v) m_busy = 0;
    if (prev_age >= 1 && prev_age <= P + S) begin
      // writer blocked and reader idle while the buffers are exchanging
    end else if (m_pending) begin
      if (rfd_v) new_swap = 1;
    end else if (w_done) begin
      if (!busy_before || rfd_v) new_swap = 1;
      else                       m_pending = 1;
    end else if (rfd_v) begin
      rescan = 1;
    end
    if (new_swap) begin
      last_swap = edge_n - 1;
      m_swapped++;
      m_valid   = 1;
      m_pending = 0;
    end
    age  = edge_n - last_swap;
    m_st = (age >= 1) && (age <= P);
    m_wa = !m_pending && !((age >= 1) && (age <= P + S));
    m_rs = rescan || (age == P + S + 1);
    if (m_rs) m_busy = 1;
  endtask

  task automatic compare_all();
    check("write_allow",      32'(wa),  32'(m_wa));
    check("read_start",       32'(rs),  32'(m_rs));
    check("swap_trigger",     32'(st),  32'(m_st));
    check("data_valid",       32'(dv),  32'(m_valid));
    check("frames_swapped",   32'(fs),  32'(m_swapped % 65536));
    check("frames_dropped",   32'(fd),  32'((m_dropped > 65535) ? 65535 : m_dropped));
    check("n_write_allow",    32'(wa2), 32'(m_wa));
    check("n_read_start",     32'(rs2), 32'(m_rs));
    check("n_swap_trigger",   32'(st2), 32'(m_st));
    check("n_frames_swapped", 32'(fs2), 32'(m_swapped % 4));
    check("n_frames_dropped", 32'(fd2), 32'((m_dropped > 3) ? 3 : m_dropped));
  endtask

  task automatic step(input bit r, input bit w_start, input bit w_done, input bit r_done);
    @(negedge clk);
    rst = r; wfs = w_start; wfd = w_done; rfd = r_done;
    @(posedge clk);
    edge_n++;
    model_edge(r, w_start, w_done, r_done);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    // Reset, then first frame into an empty buffer.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(9);
    step(0, 0, 1, 0);
    idle(20);

    // Idle reader rescan: no new frame, scan-out restarted one cycle later.
    step(0, 0, 0, 1);
    idle(5);

    // Reader busy: frame parks in PENDING, three refused starts, then swap.
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    idle(10);
    step(0, 0, 0, 1);
    idle(20);

    // Simultaneous writer and reader completion.
    step(0, 0, 1, 1);
    idle(20);

    // More refused starts so the narrow counter saturates.
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    idle(20);

    // Reset asserted during the second swap cycle.
    step(0, 0, 1, 1);
    idle(1);
    step(1, 0, 0, 0);
    idle(3);

    // Random event pulses with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 999) < 2),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 8));
    end
    idle(P + S + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
